// File: rtl/bp_cfg_loader.sv
// ----------------------------------------------------------------------------
// bp_cfg_loader: cfg-link boot sequencer (reset, freeze, modes, ucode, PC, go).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module bp_cfg_loader #(
  parameter int unsigned cfg_addr_width_p = 16,
  parameter int unsigned cfg_data_width_p = 32,
  parameter int unsigned ucode_els_p      = 256,
  parameter logic [63:0] start_pc_p       = 64'h8000_0000,
  parameter int unsigned icache_mode_p    = 1,
  parameter int unsigned dcache_mode_p    = 1,
  parameter int unsigned cce_mode_p       = 1,
  localparam int unsigned UC_ADDR_W = (ucode_els_p > 1) ? $clog2(ucode_els_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  output logic [UC_ADDR_W-1:0]        ucode_addr_o,
  output logic                        ucode_v_o,
  input  logic [cfg_data_width_p-1:0] ucode_data_i,
  output logic                        cfg_v_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ready_i,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned AW    = cfg_addr_width_p;
  localparam int unsigned DW    = cfg_data_width_p;
  localparam int unsigned CNT_W = $clog2(ucode_els_p) + 1;

  localparam logic [AW-1:0] ADDR_RESET   = AW'(32'h0001);
  localparam logic [AW-1:0] ADDR_FREEZE  = AW'(32'h0002);
  localparam logic [AW-1:0] ADDR_ICACHE  = AW'(32'h0022);
  localparam logic [AW-1:0] ADDR_DCACHE  = AW'(32'h0042);
  localparam logic [AW-1:0] ADDR_CCE     = AW'(32'h0060);
  localparam logic [AW-1:0] ADDR_PC_LO   = AW'(32'h0040);
  localparam logic [AW-1:0] ADDR_PC_HI   = AW'(32'h0041);
  localparam logic [AW-1:0] ADDR_UC_BASE = AW'(32'h8000);

  typedef enum logic [3:0] {
    S_IDLE, S_RST1, S_FRZ1, S_RST0, S_ICM, S_DCM, S_UC_FETCH, S_UC_SEND,
    S_CCEM, S_PCLO, S_PCHI, S_FRZ0, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             cfg_v_q, cfg_v_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uc_first_q, uc_first_d;
  logic [1:0]       rst_sync_q;
  logic             rst_n;
  logic             xfer;
  logic             uc_last;

  // Assert asynchronously, release two clocks after reset_n_i rises.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign xfer    = cfg_v_q & cfg_ready_i;
  assign uc_last = (cnt_q == CNT_W'(ucode_els_p - 1));

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cfg_v_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      uc_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_v_q    <= cfg_v_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      uc_first_q <= uc_first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cfg_v_d    = cfg_v_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    uc_first_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_RST1;
          cfg_v_d = 1'b1;
          addr_d  = ADDR_RESET;
          data_d  = DW'(1);
          cnt_d   = '0;
        end
      end
      S_RST1: if (xfer) begin
        state_d = S_FRZ1; addr_d = ADDR_FREEZE; data_d = DW'(1);
      end
      S_FRZ1: if (xfer) begin
        state_d = S_RST0; addr_d = ADDR_RESET; data_d = DW'(0);
      end
      S_RST0: if (xfer) begin
        state_d = S_ICM; addr_d = ADDR_ICACHE; data_d = DW'(icache_mode_p);
      end
      S_ICM: if (xfer) begin
        state_d = S_DCM; addr_d = ADDR_DCACHE; data_d = DW'(dcache_mode_p);
      end
      S_DCM: if (xfer) begin
        state_d = S_UC_FETCH; cfg_v_d = 1'b0;
      end
      S_UC_FETCH: begin
        state_d    = S_UC_SEND;
        cfg_v_d    = 1'b1;
        addr_d     = ADDR_UC_BASE | AW'(cnt_q);
        uc_first_d = 1'b1;
      end
      S_UC_SEND: begin
        // ROM data is only valid in the first send cycle; latch it for stalls.
        if (uc_first_q) data_d = ucode_data_i;
        if (xfer) begin
          if (uc_last) begin
            state_d = S_CCEM; addr_d = ADDR_CCE; data_d = DW'(cce_mode_p);
          end else begin
            state_d = S_UC_FETCH; cfg_v_d = 1'b0; cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CCEM: if (xfer) begin
        state_d = S_PCLO; addr_d = ADDR_PC_LO; data_d = DW'(start_pc_p[31:0]);
      end
      S_PCLO: if (xfer) begin
        state_d = S_PCHI; addr_d = ADDR_PC_HI; data_d = DW'(start_pc_p[63:32]);
      end
      S_PCHI: if (xfer) begin
        state_d = S_FRZ0; addr_d = ADDR_FREEZE; data_d = DW'(0);
      end
      S_FRZ0: if (xfer) begin
        state_d = S_DONE; cfg_v_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ucode_v_o    = (state_q == S_UC_FETCH);
  assign ucode_addr_o = cnt_q[UC_ADDR_W-1:0];
  assign cfg_v_o      = cfg_v_q;
  assign cfg_addr_o   = addr_q;
  assign cfg_data_o   = (state_q == S_UC_SEND && uc_first_q) ? ucode_data_i : data_q;
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o       = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_bp_cfg_loader.sv
// ----------------------------------------------------------------------------
// tb_bp_cfg_loader: scoreboard bench for bp_cfg_loader with 1, 4 and 4096 ucode words.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_bp_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start0, start1, start2;

  logic [1:0]  ua0;  logic uv0; logic [31:0] ud0;
  logic        cv0;  logic [15:0] ca0; logic [31:0] cd0;
  logic        rdy0 = 1'b1; logic busy0, done0;

  logic [0:0]  ua1;  logic uv1; logic [31:0] ud1;
  logic        cv1;  logic [15:0] ca1; logic [31:0] cd1;
  logic        busy1, done1;

  logic [11:0] ua2;  logic uv2; logic [31:0] ud2;
  logic        cv2;  logic [15:0] ca2; logic [31:0] cd2;
  logic        busy2, done2;

  bp_cfg_loader #(.ucode_els_p(4)) u_dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start0),
    .ucode_addr_o(ua0), .ucode_v_o(uv0), .ucode_data_i(ud0),
    .cfg_v_o(cv0), .cfg_addr_o(ca0), .cfg_data_o(cd0), .cfg_ready_i(rdy0),
    .busy_o(busy0), .done_o(done0));

  bp_cfg_loader #(.ucode_els_p(1)) u_dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start1),
    .ucode_addr_o(ua1), .ucode_v_o(uv1), .ucode_data_i(ud1),
    .cfg_v_o(cv1), .cfg_addr_o(ca1), .cfg_data_o(cd1), .cfg_ready_i(1'b1),
    .busy_o(busy1), .done_o(done1));

  bp_cfg_loader #(.ucode_els_p(4096)) u_dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start2),
    .ucode_addr_o(ua2), .ucode_v_o(uv2), .ucode_data_i(ud2),
    .cfg_v_o(cv2), .cfg_addr_o(ca2), .cfg_data_o(cd2), .cfg_ready_i(1'b1),
    .busy_o(busy2), .done_o(done2));

  // ROM models: rom[i] = 0xA0 + i, one-cycle read latency.
  always @(posedge clk) begin
    if (uv0) ud0 <= 32'hA0 + 32'(ua0);
    if (uv1) ud1 <= 32'hA0 + 32'(ua1);
    if (uv2) ud2 <= 32'hA0 + 32'(ua2);
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [47:0] q0[$], q1[$], q2[$];
  int wcnt0 = 0, wcnt1 = 0, wcnt2 = 0;
  int nuv0 = 0, nuv1 = 0, nuv2 = 0;
  logic [15:0] last_uc2 = '0;
  logic bp_en = 1'b0, stall8003 = 1'b0;
  int stall_left = 0;
  logic hold_pend = 1'b0;
  logic [15:0] hold_a;
  logic [31:0] hold_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] exp_write(input int els, input int k);
    logic [47:0] r;
    int j;
    j = k - 5 - els;
    if      (k == 0)      r = {16'h0001, 32'h1};
    else if (k == 1)      r = {16'h0002, 32'h1};
    else if (k == 2)      r = {16'h0001, 32'h0};
    else if (k == 3)      r = {16'h0022, 32'h1};
    else if (k == 4)      r = {16'h0042, 32'h1};
    else if (k < 5 + els) r = {16'(32'h8000 + 32'(k - 5)), 32'hA0 + 32'(k - 5)};
    else if (j == 0)      r = {16'h0060, 32'h1};
    else if (j == 1)      r = {16'h0040, 32'h8000_0000};
    else if (j == 2)      r = {16'h0041, 32'h0};
    else                  r = {16'h0002, 32'h0};
    return r;
  endfunction

  task automatic sb_pop(input int id, input logic [15:0] a, input logic [31:0] d);
    logic [47:0] e;
    int sz;
    sz = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      n_checks++; n_fail++;
      $display("FAIL unexpected_write dut%0d: got addr 0x%0h data 0x%0h, expected none", id, a, d);
    end else begin
      if (id == 0)      e = q0.pop_front();
      else if (id == 1) e = q1.pop_front();
      else              e = q2.pop_front();
      check($sformatf("write_dut%0d", id), {16'h0, a, d}, {16'h0, e});
    end
  endtask

  // Monitor: pop and compare on each transfer; check stall stability.
  always @(negedge clk) begin
    if (cv0 && rdy0) begin sb_pop(0, ca0, cd0); wcnt0++; end
    if (cv1) begin sb_pop(1, ca1, cd1); wcnt1++; end
    if (cv2) begin
      sb_pop(2, ca2, cd2); wcnt2++;
      if (ca2[15]) last_uc2 = ca2;
    end
    if (uv0) nuv0++;
    if (uv1) nuv1++;
    if (uv2) nuv2++;
    if (cv0) begin
      if (hold_pend) begin
        check("stall_addr_stable", {48'h0, ca0}, {48'h0, hold_a});
        check("stall_data_stable", {32'h0, cd0}, {32'h0, hold_d});
      end
      hold_pend = !rdy0;
      hold_a    = ca0;
      hold_d    = cd0;
    end else begin
      hold_pend = 1'b0;
    end
  end

  // Ready driver: free-running, 0..5 random stall cycles, or held low on 0x8003.
  always @(posedge clk) begin
    #1;
    if (stall8003 && cv0 && ca0 == 16'h8003) rdy0 = 1'b0;
    else if (!bp_en)                          rdy0 = 1'b1;
    else if (stall_left == 0) begin
      rdy0 = 1'b1; stall_left = $urandom_range(0, 5);
    end else begin
      rdy0 = 1'b0; stall_left--;
    end
  end

  task automatic pulse_start(input int id);
    @(posedge clk); #1;
    if (id == 0) start0 = 1'b1; else if (id == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_done(input int id, input int budget);
    logic d;
    d = 1'b0;
    for (int c = 0; c < budget && !d; c++) begin
      @(negedge clk); #1;
      d = (id == 0) ? done0 : (id == 1) ? done1 : done2;
    end
    check($sformatf("done_reached_dut%0d", id), {63'h0, d}, 64'h1);
  endtask

  task automatic run_main(input string tag, input int extra_pulses);
    int w, u;
    w = wcnt0; u = nuv0;
    for (int k = 0; k < 13; k++) q0.push_back(exp_write(4, k));
    pulse_start(0);
    check({tag, "_done_cleared"}, {63'h0, done0}, 64'h0);
    check({tag, "_busy_set"}, {63'h0, busy0}, 64'h1);
    for (int p = 0; p < extra_pulses; p++) begin
      repeat (3) @(posedge clk);
      pulse_start(0);
    end
    wait_done(0, 2000);
    check({tag, "_busy_after"}, {63'h0, busy0}, 64'h0);
    check({tag, "_write_count"}, 64'(wcnt0 - w), 64'd13);
    check({tag, "_ucode_v_count"}, 64'(nuv0 - u), 64'd4);
    check({tag, "_queue_empty"}, 64'(q0.size()), 64'd0);
  endtask

  task automatic run_sec(input int id, input int els);
    int w, u;
    w = (id == 1) ? wcnt1 : wcnt2;
    u = (id == 1) ? nuv1 : nuv2;
    for (int k = 0; k < els + 9; k++) begin
      if (id == 1) q1.push_back(exp_write(els, k));
      else         q2.push_back(exp_write(els, k));
    end
    pulse_start(id);
    wait_done(id, 20000);
    if (id == 1) begin
      check("els1_write_count", 64'(wcnt1 - w), 64'd10);
      check("els1_ucode_v_count", 64'(nuv1 - u), 64'd1);
      check("els1_queue_empty", 64'(q1.size()), 64'd0);
    end else begin
      check("els4096_write_count", 64'(wcnt2 - w), 64'd4105);
      check("els4096_ucode_v_count", 64'(nuv2 - u), 64'd4096);
      check("els4096_last_uc_addr", {48'h0, last_uc2}, 64'h8FFF);
      check("els4096_queue_empty", 64'(q2.size()), 64'd0);
    end
  endtask

  initial begin
    logic found;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    #1;
    check("rst_cfg_v", {63'h0, cv0}, 64'h0);
    check("rst_ucode_v", {63'h0, uv0}, 64'h0);
    check("rst_busy", {63'h0, busy0}, 64'h0);
    check("rst_done", {63'h0, done0}, 64'h0);
    check("rst_cfg_addr", {48'h0, ca0}, 64'h0);
    check("rst_cfg_data", {32'h0, cd0}, 64'h0);
    check("rst_ucode_addr", {62'h0, ua0}, 64'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_write_after_release", {63'h0, cv0}, 64'h0);
    end
    repeat (3) @(posedge clk);

    run_main("run_ready1", 0);
    bp_en = 1'b1;
    run_main("run_backpressure", 0);
    run_main("run_start_while_busy", 3);
    bp_en = 1'b0;
    run_main("run_restart", 0);

    // Reset while stalled on ucode word 3.
    stall8003 = 1'b1;
    for (int k = 0; k < 8; k++) q0.push_back(exp_write(4, k));
    pulse_start(0);
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk); #1;
      if (cv0 && ca0 == 16'h8003) found = 1'b1;
    end
    check("reached_8003", {63'h0, found}, 64'h1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cfg_v", {63'h0, cv0}, 64'h0);
    check("async_rst_busy", {63'h0, busy0}, 64'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    stall8003 = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("post_rst_cfg_v", {63'h0, cv0}, 64'h0);
      check("post_rst_busy", {63'h0, busy0}, 64'h0);
      check("post_rst_done", {63'h0, done0}, 64'h0);
    end
    check("rst_test_queue_empty", 64'(q0.size()), 64'd0);
    repeat (3) @(posedge clk);

    run_sec(1, 1);
    run_sec(2, 4096);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
